lb_master_arb: RTL and testbench

//  Two-master arbiter for the 24-bit address / 32-bit data localbus.

---
 rtl/lb_master_arb_if.sv | 48 ++++
 rtl/lb_master_arb.sv | 186 ++++++++++++++++++
 tb/tb_lb_master_arb.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lb_master_arb_if.sv
// Localbus arbiter bundle: two command masters on one side, the slave decoder on the other.
// The slave modport is the arbiter's view; the master modport is the requester/decoder side.
interface lb_master_arb_if #(
  parameter int AW = 24,
  parameter int DW = 32
);
  logic          m0_stb;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_rd;
  logic          m0_busy;
  logic          m0_done;
  logic [DW-1:0] m0_rdata;
  logic          m0_overrun;

  logic          m1_stb;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_rd;
  logic          m1_busy;
  logic          m1_done;
  logic [DW-1:0] m1_rdata;
  logic          m1_overrun;

  logic [AW-1:0] lb_addr;
  logic [DW-1:0] lb_dout;
  logic          lb_strobe;
  logic          lb_rd;
  logic [DW-1:0] lb_din;

  modport slave (
    input  m0_stb, m0_addr, m0_wdata, m0_rd,
    input  m1_stb, m1_addr, m1_wdata, m1_rd,
    input  lb_din,
    output m0_busy, m0_done, m0_rdata, m0_overrun,
    output m1_busy, m1_done, m1_rdata, m1_overrun,
    output lb_addr, lb_dout, lb_strobe, lb_rd
  );

  modport master (
    output m0_stb, m0_addr, m0_wdata, m0_rd,
    output m1_stb, m1_addr, m1_wdata, m1_rd,
    output lb_din,
    input  m0_busy, m0_done, m0_rdata, m0_overrun,
    input  m1_busy, m1_done, m1_rdata, m1_overrun,
    input  lb_addr, lb_dout, lb_strobe, lb_rd
  );
endinterface

// File: rtl/lb_master_arb.sv
// Two-master localbus arbiter: one queued command per master, alternating grant on ties,
// single-cycle strobe to the decoder and fixed-latency read data return.
module lb_master_arb #(
  parameter int AW       = 24,
  parameter int DW       = 32,
  parameter int READ_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  lb_master_arb_if.slave      bus
);
  localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    pend_q, pend_d;
  logic [AW-1:0] addr_q [2];
  logic [AW-1:0] addr_d [2];
  logic [DW-1:0] wdata_q [2];
  logic [DW-1:0] wdata_d [2];
  logic [1:0]    rd_q, rd_d;
  logic [1:0]    overrun_q, overrun_d;
  logic          last_grant_q, last_grant_d;
  logic          owner_q, owner_d;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] lb_addr_q, lb_addr_d;
  logic [DW-1:0] lb_dout_q, lb_dout_d;
  logic          lb_rd_q, lb_rd_d;
  logic          lb_strobe_q, lb_strobe_d;
  logic [1:0]    done_q, done_d;
  logic [DW-1:0] rdata_q [2];
  logic [DW-1:0] rdata_d [2];

  logic [1:0]    stb_s;
  logic [1:0]    cmd_rd_s;
  logic [AW-1:0] cmd_addr_s [2];
  logic [DW-1:0] cmd_wdata_s [2];
  logic [1:0]    busy_s;
  logic          grant_s;

  assign stb_s          = {bus.m1_stb, bus.m0_stb};
  assign cmd_rd_s       = {bus.m1_rd, bus.m0_rd};
  assign cmd_addr_s[0]  = bus.m0_addr;
  assign cmd_addr_s[1]  = bus.m1_addr;
  assign cmd_wdata_s[0] = bus.m0_wdata;
  assign cmd_wdata_s[1] = bus.m1_wdata;

  // Busy covers a queued command and the in-flight one; inflight clears on the edge that raises done.
  assign busy_s[0] = pend_q[0] | (inflight_q & (owner_q == 1'b0));
  assign busy_s[1] = pend_q[1] | (inflight_q & (owner_q == 1'b1));

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    overrun_d    = overrun_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    inflight_d   = inflight_q;
    cnt_d        = cnt_q;
    lb_addr_d    = lb_addr_q;
    lb_dout_d    = lb_dout_q;
    lb_rd_d      = lb_rd_q;
    lb_strobe_d  = 1'b0;
    done_d       = 2'b00;
    rdata_d      = rdata_q;
    grant_s      = 1'b0;

    for (int n = 0; n < 2; n++) begin
      if (stb_s[n]) begin
        if (busy_s[n]) begin
          overrun_d[n] = 1'b1;
        end else begin
          pend_d[n]  = 1'b1;
          addr_d[n]  = cmd_addr_s[n];
          wdata_d[n] = cmd_wdata_s[n];
          rd_d[n]    = cmd_rd_s[n];
        end
      end else begin
        pend_d[n] = pend_d[n];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (pend_q != 2'b00) begin
          grant_s         = (pend_q == 2'b11) ? ~last_grant_q : pend_q[1];
          lb_addr_d       = addr_q[grant_s];
          lb_dout_d       = wdata_q[grant_s];
          lb_rd_d         = rd_q[grant_s];
          pend_d[grant_s] = 1'b0;
          last_grant_d    = grant_s;
          owner_d         = grant_s;
          inflight_d      = 1'b1;
          lb_strobe_d     = 1'b1;
          state_d         = S_STROBE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STROBE: begin
        if (lb_rd_q) begin
          cnt_d   = CW'(READ_LAT - 1);
          state_d = S_WAIT;
        end else begin
          done_d[owner_q] = 1'b1;
          inflight_d      = 1'b0;
          state_d         = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d[owner_q] = bus.lb_din;
          done_d[owner_q]  = 1'b1;
          inflight_d       = 1'b0;
          state_d          = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any access and forgets queued commands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pend_q       <= 2'b00;
      addr_q       <= '{default: '0};
      wdata_q      <= '{default: '0};
      rd_q         <= 2'b00;
      overrun_q    <= 2'b00;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      inflight_q   <= 1'b0;
      cnt_q        <= '0;
      lb_addr_q    <= '0;
      lb_dout_q    <= '0;
      lb_rd_q      <= 1'b0;
      lb_strobe_q  <= 1'b0;
      done_q       <= 2'b00;
      rdata_q      <= '{default: '0};
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      overrun_q    <= overrun_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      inflight_q   <= inflight_d;
      cnt_q        <= cnt_d;
      lb_addr_q    <= lb_addr_d;
      lb_dout_q    <= lb_dout_d;
      lb_rd_q      <= lb_rd_d;
      lb_strobe_q  <= lb_strobe_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
    end
  end

  assign bus.m0_busy    = busy_s[0];
  assign bus.m1_busy    = busy_s[1];
  assign bus.m0_done    = done_q[0];
  assign bus.m1_done    = done_q[1];
  assign bus.m0_rdata   = rdata_q[0];
  assign bus.m1_rdata   = rdata_q[1];
  assign bus.m0_overrun = overrun_q[0];
  assign bus.m1_overrun = overrun_q[1];
  assign bus.lb_addr    = lb_addr_q;
  assign bus.lb_dout    = lb_dout_q;
  assign bus.lb_rd      = lb_rd_q;
  assign bus.lb_strobe  = lb_strobe_q;
endmodule

// File: tb/tb_lb_master_arb.sv
// Bench for lb_master_arb: directed scenarios with literal expectations plus random traffic,
// all cycles checked against a transaction-timing model of the arbiter.
module tb_lb_master_arb;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int RL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lb_master_arb_if #(.AW(AW), .DW(DW)) bus ();
  lb_master_arb #(.AW(AW), .DW(DW), .READ_LAT(RL)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [1:0]    stb_v = 2'b00;
  logic [1:0]    rd_v = 2'b00;
  logic [AW-1:0] addr_v [2] = '{default: '0};
  logic [DW-1:0] wdata_v [2] = '{default: '0};
  logic [DW-1:0] din_v = '0;
  logic          din_force = 1'b0;
  logic [DW-1:0] din_fixed = 32'h6f20776f;

  assign bus.m0_stb   = stb_v[0];
  assign bus.m1_stb   = stb_v[1];
  assign bus.m0_rd    = rd_v[0];
  assign bus.m1_rd    = rd_v[1];
  assign bus.m0_addr  = addr_v[0];
  assign bus.m1_addr  = addr_v[1];
  assign bus.m0_wdata = wdata_v[0];
  assign bus.m1_wdata = wdata_v[1];
  assign bus.lb_din   = din_v;

  wire [1:0] busy_o = {bus.m1_busy, bus.m0_busy};
  wire [1:0] done_o = {bus.m1_done, bus.m0_done};
  wire [1:0] ovr_o  = {bus.m1_overrun, bus.m0_overrun};

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Decoder stand-in: fresh random read data every cycle unless a test pins it.
  always @(posedge clk) begin
    #1;
    din_v = din_force ? din_fixed : $urandom;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a granted command's strobe and done cycles are fixed offsets from its grant.
  bit            m_on = 1'b0;
  bit            m_pend [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wdata [2];
  bit            m_rd [2];
  bit            m_act = 1'b0;
  bit            m_own;
  bit            m_act_rd;
  int unsigned   m_scyc, m_dcyc;
  bit            m_last;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_dout;
  bit            e_rd;
  logic [DW-1:0] e_rdata [2];
  bit            e_ovr [2];

  always @(negedge clk) begin
    bit busy_e [2];
    bit g;
    for (int n = 0; n < 2; n++)
      busy_e[n] = m_pend[n] || (m_act && (m_own == n[0]) && (cyc < m_dcyc));
    if (m_on) begin
      chk("lb_strobe", bus.lb_strobe, m_act && (cyc == m_scyc));
      chk("lb_addr", bus.lb_addr, e_addr);
      chk("lb_dout", bus.lb_dout, e_dout);
      chk("lb_rd", bus.lb_rd, e_rd);
      for (int n = 0; n < 2; n++) begin
        chk($sformatf("m%0d_done", n), done_o[n], m_act && (m_own == n[0]) && (cyc == m_dcyc));
        chk($sformatf("m%0d_busy", n), busy_o[n], busy_e[n]);
        chk($sformatf("m%0d_overrun", n), ovr_o[n], e_ovr[n]);
      end
      chk("m0_rdata", bus.m0_rdata, e_rdata[0]);
      chk("m1_rdata", bus.m1_rdata, e_rdata[1]);
    end
    if (rst) begin
      m_on = 1'b1;
      m_act = 1'b0;
      m_last = 1'b1;
      e_addr = '0;
      e_dout = '0;
      e_rd = 1'b0;
      for (int n = 0; n < 2; n++) begin
        m_pend[n] = 1'b0;
        e_rdata[n] = '0;
        e_ovr[n] = 1'b0;
      end
    end else if (m_on) begin
      if (m_act && m_act_rd && (cyc == m_scyc + RL)) e_rdata[m_own] = din_v;
      if (m_act && (cyc == m_dcyc)) m_act = 1'b0;
      if (!m_act && (m_pend[0] || m_pend[1])) begin
        g = (m_pend[0] && m_pend[1]) ? !m_last : m_pend[1];
        m_act = 1'b1;
        m_own = g;
        m_act_rd = m_rd[g];
        m_scyc = cyc + 1;
        m_dcyc = m_rd[g] ? cyc + 2 + RL : cyc + 2;
        e_addr = m_addr[g];
        e_dout = m_wdata[g];
        e_rd = m_rd[g];
        m_pend[g] = 1'b0;
        m_last = g;
      end
      for (int n = 0; n < 2; n++) begin
        if (stb_v[n]) begin
          if (busy_e[n]) e_ovr[n] = 1'b1;
          else begin
            m_pend[n] = 1'b1;
            m_addr[n] = addr_v[n];
            m_wdata[n] = wdata_v[n];
            m_rd[n] = rd_v[n];
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int n, input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    stb_v[n] = 1'b1;
    rd_v[n] = rd;
    addr_v[n] = a;
    wdata_v[n] = d;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (((busy_o != 2'b00) || (done_o != 2'b00)) && (k < 50)) begin
      tick();
      k++;
    end
    chk("idle_timeout", (k < 50), 1'b1);
    tick();
  endtask

  initial begin
    int strobes;
    int dones;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_strobe", bus.lb_strobe, 1'b0);
    chk("rst_busy", busy_o, 2'b00);
    chk("rst_addr", bus.lb_addr, 24'h000000);
    chk("rst_rdata1", bus.m1_rdata, 32'h0);
    tick(); tick();

    // m0 write: stb at n, strobe at n+2, done at n+3
    set_cmd(0, 1'b0, 24'h002005, 32'h000000A5);
    tick(); stb_v = 2'b00;
    tick();
    @(negedge clk);
    chk("w_strobe", bus.lb_strobe, 1'b1);
    chk("w_rd", bus.lb_rd, 1'b0);
    chk("w_addr", bus.lb_addr, 24'h002005);
    chk("w_dout", bus.lb_dout, 32'h000000A5);
    tick();
    @(negedge clk);
    chk("w_done", bus.m0_done, 1'b1);
    wait_idle();

    // m1 read with pinned decoder data
    din_force = 1'b1;
    set_cmd(1, 1'b1, 24'h000001, 32'h0);
    tick(); stb_v = 2'b00;
    tick();
    @(negedge clk);
    chk("r_strobe_rd", {bus.lb_strobe, bus.lb_rd}, 2'b11);
    tick(); tick(); tick();
    @(negedge clk);
    chk("r_done", bus.m1_done, 1'b1);
    chk("r_rdata", bus.m1_rdata, 32'h6f20776f);
    din_force = 1'b0;
    wait_idle();

    // tie after reset-era history: m0 first, m1 two cycles later
    set_cmd(0, 1'b0, 24'h0000A0, 32'h11111111);
    set_cmd(1, 1'b0, 24'h0000B1, 32'h22222222);
    tick(); stb_v = 2'b00;
    tick();
    @(negedge clk);
    chk("tie1_first", {bus.lb_strobe, bus.lb_addr}, {1'b1, 24'h0000A0});
    tick(); tick();
    @(negedge clk);
    chk("tie1_second", {bus.lb_strobe, bus.lb_addr}, {1'b1, 24'h0000B1});
    wait_idle();

    // m0 granted alone, then a tie in its done cycle: m1 must win
    set_cmd(0, 1'b0, 24'h0000C0, 32'h33333333);
    tick(); stb_v = 2'b00;
    tick(); tick();
    set_cmd(0, 1'b0, 24'h0000D0, 32'h44444444);
    set_cmd(1, 1'b0, 24'h0000D1, 32'h55555555);
    tick(); stb_v = 2'b00;
    tick();
    @(negedge clk);
    chk("tie2_m1_first", {bus.lb_strobe, bus.lb_addr}, {1'b1, 24'h0000D1});
    wait_idle();

    // back-to-back m0 strobes: second is an overrun
    set_cmd(0, 1'b0, 24'h0000E0, 32'h66666666);
    tick();
    set_cmd(0, 1'b0, 24'h0000E8, 32'h77777777);
    tick(); stb_v = 2'b00;
    strobes = 0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      strobes += int'(bus.lb_strobe);
      dones += int'(bus.m0_done);
      tick();
    end
    chk("ovr_flag", bus.m0_overrun, 1'b1);
    chk("ovr_strobes", strobes, 1);
    chk("ovr_dones", dones, 1);
    wait_idle();

    // reset while m1 read is waiting on the decoder
    set_cmd(1, 1'b1, 24'h000123, 32'h0);
    tick(); stb_v = 2'b00;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_outs", {bus.lb_strobe, busy_o, done_o, ovr_o}, 7'b0);
    chk("rstw_rdata", {bus.m0_rdata, bus.m1_rdata, bus.lb_addr}, 88'h0);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      dones += int'(bus.m1_done);
    end
    chk("rstw_no_done", dones, 0);
    tick();
    set_cmd(0, 1'b0, 24'h000777, 32'h89ABCDEF);
    tick(); stb_v = 2'b00;
    tick(); tick();
    @(negedge clk);
    chk("rstw_fresh_done", bus.m0_done, 1'b1);
    wait_idle();

    // random traffic from both masters, never striking while busy
    for (int i = 0; i < 5000; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (!busy_o[n] && ($urandom_range(0, 2) == 0))
          set_cmd(n, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
        else
          stb_v[n] = 1'b0;
      end
      tick();
    end
    stb_v = 2'b00;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
